// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Opcodes, FSM states and flag indices for the ALU op sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int FLG_W  = 6;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam int FLG_Z   = 0;
  localparam int FLG_N   = 1;
  localparam int FLG_C   = 2;
  localparam int FLG_V   = 3;
  localparam int FLG_DZ  = 4;
  localparam int FLG_ERR = 5;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_if
// Brief  : Request, divider and result handshake bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              div_start;
  logic [DATA_W-1:0] div_a;
  logic [DATA_W-1:0] div_b;
  logic [RES_W-1:0]  div_quotient;
  logic              div_done;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [FLG_W-1:0]  res_flags;

  modport slave (
    input  req_valid, req_op, req_a, req_b, div_quotient, div_done, res_ready,
    output req_ready, div_start, div_a, div_b, res_valid, res_data, res_flags
  );

  modport master (
    output req_valid, req_op, req_a, req_b, div_quotient, div_done, res_ready,
    input  req_ready, div_start, div_a, div_b, res_valid, res_data, res_flags
  );

endinterface
`default_nettype wire

// File: rtl/alu_simple_exec.sv
`default_nettype none
// ============================================================================
// Module : alu_simple_exec
// Brief  : Combinational single-cycle ALU (ADD/SUB/AND/OR/XOR) with Z/N/C/V.
// Rev    : 1.0  initial release
// ============================================================================
module alu_simple_exec
  import alu_seq_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [RES_W-1:0]  o_result,
  output logic              o_z,
  output logic              o_n,
  output logic              o_c,
  output logic              o_v
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_r8;

  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b};
    w_diff = {1'b0, i_a} - {1'b0, i_b};
    w_r8   = '0;
    o_c    = 1'b0;
    o_v    = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_r8 = w_sum[DATA_W-1:0];
        o_c  = w_sum[DATA_W];
        o_v  = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is the unsigned borrow (a < b)
        w_r8 = w_diff[DATA_W-1:0];
        o_c  = w_diff[DATA_W];
        o_v  = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
      end
      OP_AND:  w_r8 = i_a & i_b;
      OP_OR:   w_r8 = i_a | i_b;
      OP_XOR:  w_r8 = i_a ^ i_b;
      default: w_r8 = '0;
    endcase
    o_result = {{(RES_W-DATA_W){w_r8[DATA_W-1]}}, w_r8};
    o_z      = (o_result == '0);
    o_n      = o_result[RES_W-1];
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_op_sequencer
// Brief  : Accepts ALU requests, runs simple ops inline, dispatches DIV.
// Rev    : 1.0  initial release
// ============================================================================
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DIV_TIMEOUT = 32
)(
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  localparam int              CNT_W   = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [RES_W-1:0]    r_res_data;
  logic [FLG_W-1:0]    r_res_flags;

  logic                w_req_ready;
  logic                w_latch;
  logic                w_cnt_clr;
  logic                w_cnt_inc;
  logic                w_div_start;
  logic                w_res_load;
  logic [RES_W-1:0]    w_res_data_nxt;
  logic [FLG_W-1:0]    w_res_flags_nxt;

  logic [RES_W-1:0]    w_exec_result;
  logic                w_exec_z;
  logic                w_exec_n;
  logic                w_exec_c;
  logic                w_exec_v;

  alu_simple_exec u_exec (
    .i_op     (bus.req_op),
    .i_a      (bus.req_a),
    .i_b      (bus.req_b),
    .o_result (w_exec_result),
    .o_z      (w_exec_z),
    .o_n      (w_exec_n),
    .o_c      (w_exec_c),
    .o_v      (w_exec_v)
  );

  assign w_req_ready = (r_state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_latch         = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    w_div_start     = 1'b0;
    w_res_load      = 1'b0;
    w_res_data_nxt  = '0;
    w_res_flags_nxt = '0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && w_req_ready) begin
          w_latch = 1'b1;
          if (bus.req_op == OP_DIV && bus.req_b != '0) begin
            w_state_nxt = LAUNCH;
          end else begin
            w_state_nxt = OUT;
            w_res_load  = 1'b1;
            if (bus.req_op == OP_DIV) begin
              w_res_flags_nxt[FLG_DZ] = 1'b1;
              w_res_flags_nxt[FLG_Z]  = 1'b1;
            end else begin
              w_res_data_nxt           = w_exec_result;
              w_res_flags_nxt[FLG_Z]   = w_exec_z;
              w_res_flags_nxt[FLG_N]   = w_exec_n;
              w_res_flags_nxt[FLG_C]   = w_exec_c;
              w_res_flags_nxt[FLG_V]   = w_exec_v;
              w_res_flags_nxt[FLG_ERR] = (bus.req_op > OP_DIV);
            end
          end
        end
      end
      LAUNCH: begin
        w_div_start = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // A completion on the final counted cycle still wins over the timeout
        if (bus.div_done) begin
          w_state_nxt            = OUT;
          w_res_load             = 1'b1;
          w_res_data_nxt         = bus.div_quotient;
          w_res_flags_nxt[FLG_Z] = (bus.div_quotient == '0);
          w_res_flags_nxt[FLG_N] = bus.div_quotient[RES_W-1];
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt              = OUT;
          w_res_load               = 1'b1;
          w_res_flags_nxt[FLG_ERR] = 1'b1;
          w_res_flags_nxt[FLG_Z]   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      OUT: begin
        if (bus.res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
    end else begin
      if (w_latch) begin
        r_a <= bus.req_a;
        r_b <= bus.req_b;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_res_load) begin
        r_res_data  <= w_res_data_nxt;
        r_res_flags <= w_res_flags_nxt;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.div_start = w_div_start;
  assign bus.div_a     = r_a;
  assign bus.div_b     = r_b;
  assign bus.res_valid = (r_state == OUT);
  assign bus.res_data  = r_res_data;
  assign bus.res_flags = r_res_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_op_sequencer
// Brief  : Directed self-checking bench for alu_op_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DIV_TIMEOUT = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if bus();

  alu_op_sequencer #(.DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 16'(bus.req_ready), 16'd0);
    chk({tag, "_div_start"}, 16'(bus.div_start), 16'd0);
    chk({tag, "_div_a"},     16'(bus.div_a),     16'd0);
    chk({tag, "_div_b"},     16'(bus.div_b),     16'd0);
    chk({tag, "_res_valid"}, 16'(bus.res_valid), 16'd0);
    chk({tag, "_res_data"},  bus.res_data,       16'd0);
    chk({tag, "_res_flags"}, 16'(bus.res_flags), 16'd0);
  endtask

  // Single-cycle request with the consumer always ready
  task automatic simple_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] ed, input logic [5:0] ef);
    chk({tag, "_req_ready"}, 16'(bus.req_ready), 16'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_res_valid"}, 16'(bus.res_valid), 16'd1);
    chk({tag, "_res_data"},  bus.res_data,       ed);
    chk({tag, "_res_flags"}, 16'(bus.res_flags), 16'(ef));
    chk({tag, "_div_start"}, 16'(bus.div_start), 16'd0);
    chk({tag, "_req_ready_busy"}, 16'(bus.req_ready), 16'd0);
    @(negedge clk);
    chk({tag, "_done_valid"}, 16'(bus.res_valid), 16'd0);
    chk({tag, "_done_ready"}, 16'(bus.req_ready), 16'd1);
  endtask

  initial begin
    int starts;
    int n;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_op       = 3'd0;
    bus.req_a        = 8'd0;
    bus.req_b        = 8'd0;
    bus.div_quotient = 16'd0;
    bus.div_done     = 1'b0;
    bus.res_ready    = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 16'(bus.req_ready), 16'd1);

    // flags = {ERR,DZ,V,C,N,Z}
    simple_op("add_ovf",  OP_ADD, 8'd100, 8'd50, 16'hFF96, 6'b001010);
    simple_op("add_cry",  OP_ADD, 8'hFF,  8'h01, 16'h0000, 6'b000101);
    simple_op("sub_eq",   OP_SUB, 8'd5,   8'd5,  16'h0000, 6'b000001);
    simple_op("sub_brw",  OP_SUB, 8'd3,   8'd7,  16'hFFFC, 6'b000110);
    simple_op("and",      OP_AND, 8'hFF,  8'h3C, 16'h003C, 6'b000000);
    simple_op("or",       OP_OR,  8'h10,  8'h01, 16'h0011, 6'b000000);
    simple_op("xor",      OP_XOR, 8'hF0,  8'h0F, 16'hFFFF, 6'b000010);
    simple_op("div_zero", OP_DIV, 8'd42,  8'd0,  16'h0000, 6'b010001);

    // DIV -100 / 7 with a hand-driven divider
    starts        = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIV;
    bus.req_a     = 8'h9C;
    bus.req_b     = 8'h07;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a     = 8'h55;
    bus.req_b     = 8'h00;
    if (bus.div_start) starts++;
    chk("div_launch_start", 16'(bus.div_start), 16'd1);
    chk("div_launch_ready", 16'(bus.req_ready), 16'd0);
    chk("div_launch_a",     16'(bus.div_a),     16'h009C);
    chk("div_launch_b",     16'(bus.div_b),     16'h0007);
    repeat (3) begin
      @(negedge clk);
      if (bus.div_start) starts++;
      chk("div_wait_a",     16'(bus.div_a),     16'h009C);
      chk("div_wait_b",     16'(bus.div_b),     16'h0007);
      chk("div_wait_valid", 16'(bus.res_valid), 16'd0);
    end
    bus.div_done     = 1'b1;
    bus.div_quotient = 16'hFFF2;
    @(negedge clk);
    bus.div_done = 1'b0;
    if (bus.div_start) starts++;
    chk("div_res_valid", 16'(bus.res_valid), 16'd1);
    chk("div_res_data",  bus.res_data,       16'hFFF2);
    chk("div_res_flags", 16'(bus.res_flags), 16'b000010);
    chk("div_out_a",     16'(bus.div_a),     16'h009C);
    chk("div_starts",    16'(starts),        16'd1);
    @(negedge clk);
    chk("div_idle_valid", 16'(bus.res_valid), 16'd0);

    // Illegal opcode under backpressure
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b110;
    bus.req_a     = 8'd9;
    bus.req_b     = 8'd9;
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) begin
      chk("ill_valid", 16'(bus.res_valid), 16'd1);
      chk("ill_data",  bus.res_data,       16'h0000);
      chk("ill_flags", 16'(bus.res_flags), 16'b100001);
      chk("ill_ready", 16'(bus.req_ready), 16'd0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("ill_rel_valid", 16'(bus.res_valid), 16'd0);
    simple_op("after_ill", OP_ADD, 8'd1, 8'd2, 16'h0003, 6'b000000);

    // DIV timeout: divider never answers
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIV;
    bus.req_a     = 8'd10;
    bus.req_b     = 8'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 16'(n),             16'(DIV_TIMEOUT + 2));
    chk("to_data",    bus.res_data,       16'h0000);
    chk("to_flags",   16'(bus.res_flags), 16'b100001);
    @(negedge clk);
    chk("to_idle", 16'(bus.req_ready), 16'd1);

    // Reset while in WAIT, then a late div_done
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIV;
    bus.req_a     = 8'd20;
    bus.req_b     = 8'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_wait");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", 16'(bus.req_ready), 16'd1);
    bus.div_done     = 1'b1;
    bus.div_quotient = 16'd5;
    @(negedge clk);
    bus.div_done = 1'b0;
    chk("stray_valid", 16'(bus.res_valid), 16'd0);
    chk("stray_data",  bus.res_data,       16'h0000);
    chk("stray_ready", 16'(bus.req_ready), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end sequencer for the 8-bit ALU. It accepts operation requests over a valid/ready handshake and latches the operands.
- ADD/SUB/AND/OR/XOR are executed internally in one cycle.
- DIV is dispatched to the multi-cycle signed divider over a start/done interface. The divider operands are held stable for the whole divide.
- The 16-bit result and status flags are presented to the downstream consumer over a valid/ready handshake.

Parameters:
- DIV_TIMEOUT, 32: maximum cycles spent in WAIT for div_done before the divide is aborted with ERR.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request; equals (state==IDLE)
- req_op  in  3  opcode
- req_a  in  8  operand A, signed
- req_b  in  8  operand B, signed
- div_start  out  1  one-cycle start pulse to the divider
- div_a  out  8  divider dividend; latched A
- div_b  out  8  divider divisor; latched B
- div_quotient  in  16  signed divider result
- div_done  in  1  one-cycle divider completion pulse
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts the result
- res_data  out  16  signed result
- res_flags  out  6  {ERR,DZ,V,C,N,Z}

Behaviour:
- Reset values: req_ready=0 during reset, 1 after reset. div_start=0, div_a=0, div_b=0, res_valid=0, res_data=0, res_flags=0. Internal state=IDLE, timeout counter=0.
- Reset mid-operation: the sequencer returns to IDLE on the next edge and the pending result is discarded. The divider shares the same reset.
- States and transitions:
  - IDLE: on req_valid&req_ready, latch op/a/b, then go to:
    - LAUNCH if op=DIV and b!=0;
    - OUT otherwise, with the result computed and registered on the same edge.
  - LAUNCH: div_start=1 for exactly this cycle; go to WAIT.
  - WAIT: wait for div_done, counting cycles.
    - div_done=1: register res_data=div_quotient; go to OUT.
    - Counter reaches DIV_TIMEOUT-1 without div_done: res_data=0, ERR=1; go to OUT.
  - OUT: res_valid=1. res_data/res_flags stay stable until res_ready=1, then go to IDLE with res_valid=0 on the next edge.
- div_a/div_b are driven from the latched operand registers from acceptance until the sequencer returns to IDLE. They never follow req_a/req_b mid-operation.
- div_done is sampled only in WAIT. A stray or late pulse in any other state is ignored.
- Latency:
  - Single-cycle ops: res_valid is asserted the cycle after acceptance.
  - DIV: res_valid is asserted the cycle after div_done is sampled.
  - Divide by zero: res_valid is asserted the cycle after acceptance.
- Arithmetic results (a, b are signed 8-bit):
  - ADD/SUB: r8 = a±b, modulo 2^8.
  - AND/OR/XOR: bitwise, 8-bit.
  - res_data = r8 sign-extended to 16 bits.
  - DIV: res_data = div_quotient unchanged (truncated toward zero).
- Flags:
  - Z = (res_data==0).
  - N = res_data[15].
  - C: ADD gives the unsigned carry out of bit 7; SUB gives the borrow (unsigned a<b). C=0 for all other ops.
  - V: signed overflow, for ADD/SUB only; 0 otherwise.
  - DZ=1 when op=DIV and b==0. In that case res_data=0, Z=1, and the divider is not started.
  - ERR=1 on an illegal opcode (110/111, with res_data=0 and Z=1) or on a DIV timeout (also Z=1).
- Back-to-back requests: req_ready is low in LAUNCH, WAIT and OUT. A request can be accepted at the earliest one cycle after the result handshake.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams: OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_DIV=3'b101;
  - state encodings IDLE/LAUNCH/WAIT/OUT;
  - flag bit indices FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3, FLG_DZ=4, FLG_ERR=5.
- One sub-module, alu_simple_exec: combinational single-cycle ALU taking op, a, b and returning the 16-bit result plus Z/N/C/V. The sequencer FSM, latches and timeout counter stay in the top module.

Test Plan:
- ADD a=100, b=50, res_ready=1 -> res_valid 1 cycle after accept; res_data=16'hFF96 (-106); flags V=1, N=1, C=0, Z=0.
- SUB a=5, b=5 -> res_data=0; Z=1, C=0, V=0. SUB a=3, b=7 -> res_data=16'hFFFC; C=1, N=1.
- DIV a=-100, b=7 with the divider attached -> exactly one div_start pulse; div_a/div_b stable at 8'h9C/8'h07 throughout; res_data=16'hFFF2 (-14) the cycle after div_done; N=1.
- DIV a=42, b=0 -> no div_start; res_data=0; DZ=1, Z=1, res_valid the cycle after accept.
- Backpressure and illegal op:
  - Op 3'b110 with res_ready held 0 for 5 cycles -> res_valid/res_data/res_flags stable with ERR=1, req_ready=0.
  - Raising res_ready -> IDLE next cycle, then a new request is accepted.
- Timeout and reset:
  - DIV with div_done tied 0 -> ERR=1, res_data=0 after DIV_TIMEOUT cycles in WAIT.
  - Separately, reset asserted in WAIT -> next cycle all outputs at reset values; a subsequent div_done pulse is ignored.
